// File: rtl/reset_sequencer_pkg.sv
// Shared types for the staged reset sequencer: FSM state encoding and
// loss-counter width.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      RESET     = 2'd0,
      WAIT_LOCK = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } rst_seq_state_t;

   localparam int LOSS_CNT_W = 8;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for bringing asynchronous level signals into clk.
// Both flops reset to 0.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_meta;
   (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: waits for a stable PLL lock, then drops rst_stage bits
// one by one. Optional lock-loss counter enabled by RST_SEQ_LOSS_CNT_EN.
module reset_sequencer
   import rst_seq_pkg::*;
#(
   parameter int STAGES      = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int LOCK_STABLE = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  locked_in,
   input  logic                  sw_rst,
   output logic [STAGES-1:0]     rst_stage,
   output logic                  ready,
   output logic [1:0]            state
`ifdef RST_SEQ_LOSS_CNT_EN
   ,
   output logic [LOSS_CNT_W-1:0] loss_cnt
`endif
);

   localparam int REL_CYCLES = STAGES * HOLD_CYCLES;
   localparam int CNT_MAX    = max_i(LOCK_STABLE, REL_CYCLES);
   localparam int CW         = $clog2(CNT_MAX + 1);

   logic           w_locked_s;
   logic           w_run_phase;
   logic           w_fault;
   logic [CW-1:0]  w_cnt_inc;

   rst_seq_state_t r_state;
   logic [CW-1:0]  r_cnt;
   logic [STAGES-1:0] r_stage;
   logic           r_ready;

   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (locked_in),
      .o_q   (w_locked_s)
   );

   // Lock loss only faults once sequencing has started; in WAIT_LOCK it just
   // restarts the stability count.
   assign w_run_phase = (r_state == RELEASE) || (r_state == RUN);
   assign w_fault     = sw_rst || (w_run_phase && !w_locked_s);
   assign w_cnt_inc   = r_cnt + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RESET;
         r_cnt   <= '0;
         r_stage <= '1;
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            RESET: begin
               r_state <= WAIT_LOCK;
               r_cnt   <= '0;
            end
            WAIT_LOCK: begin
               if (sw_rst) begin
                  r_state <= RESET;
                  r_cnt   <= '0;
               end else if (!w_locked_s) begin
                  r_cnt <= '0;
               end else if (r_cnt == CW'(LOCK_STABLE - 1)) begin
                  r_state <= RELEASE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            RELEASE: begin
               if (w_fault) begin
                  r_state <= RESET;
                  r_cnt   <= '0;
                  r_stage <= '1;
                  r_ready <= 1'b0;
               end else begin
                  r_cnt <= w_cnt_inc;
                  // Stage k drops on the edge that completes (k+1)*HOLD_CYCLES cycles.
                  for (int k = 0; k < STAGES; k++) begin
                     if (w_cnt_inc == CW'((k + 1) * HOLD_CYCLES))
                        r_stage[k] <= 1'b0;
                  end
                  if (w_cnt_inc == CW'(REL_CYCLES)) begin
                     r_state <= RUN;
                     r_ready <= 1'b1;
                     r_cnt   <= '0;
                  end
               end
            end
            RUN: begin
               if (w_fault) begin
                  r_state <= RESET;
                  r_cnt   <= '0;
                  r_stage <= '1;
                  r_ready <= 1'b0;
               end
            end
            default: begin
               r_state <= RESET;
               r_cnt   <= '0;
               r_stage <= '1;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign rst_stage = r_stage;
   assign ready     = r_ready;
   assign state     = r_state;

`ifdef RST_SEQ_LOSS_CNT_EN
   logic [LOSS_CNT_W-1:0] r_loss_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_loss_cnt <= '0;
      else if (w_run_phase && !w_locked_s && (r_loss_cnt != '1))
         r_loss_cnt <= r_loss_cnt + 1'b1;
   end

   assign loss_cnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer (STAGES=3, HOLD_CYCLES=4, LOCK_STABLE=8) against
// a phase/age reference model; covers RST_SEQ_LOSS_CNT_EN when defined.
module tb_reset_sequencer;

   localparam int S   = 3;
   localparam int H   = 4;
   localparam int LS  = 8;
   localparam int REL = S * H;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         locked_in = 1'b0;
   logic         sw_rst = 1'b0;
   logic [S-1:0] rst_stage;
   logic         ready;
   logic [1:0]   state;
`ifdef RST_SEQ_LOSS_CNT_EN
   logic [7:0]   loss_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Model: phase 0=reset, 1=waiting for lock, 2=sequencing (age = cycles since start)
   int   m_ph, m_stable, m_age, m_loss;
   logic m_ls1, m_ls2;

   always #5 clk = ~clk;

   reset_sequencer #(.STAGES(S), .HOLD_CYCLES(H), .LOCK_STABLE(LS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .locked_in (locked_in),
      .sw_rst    (sw_rst),
      .rst_stage (rst_stage),
      .ready     (ready),
      .state     (state)
`ifdef RST_SEQ_LOSS_CNT_EN
      ,
      .loss_cnt  (loss_cnt)
`endif
   );

   function automatic logic [S+2:0] exp_vec();
      logic [S-1:0] st;
      logic [1:0]   ps;
      logic         rd;
      st = '1;
      rd = 1'b0;
      ps = (m_ph == 0) ? 2'd0 : 2'd1;
      if (m_ph == 2) begin
         rd = (m_age >= REL);
         ps = rd ? 2'd3 : 2'd2;
         for (int k = 0; k < S; k++) st[k] = (m_age < (k + 1) * H);
      end
      return {ps, rd, st};
   endfunction

   task automatic model_rst();
      m_ph = 0; m_stable = 0; m_age = 0; m_loss = 0; m_ls1 = 0; m_ls2 = 0;
   endtask

   task automatic model_edge();
      case (m_ph)
         0: begin m_ph = 1; m_stable = 0; end
         1: begin
            if (sw_rst) m_ph = 0;
            else if (!m_ls2) m_stable = 0;
            else if (m_stable + 1 == LS) begin m_ph = 2; m_age = 0; end
            else m_stable++;
         end
         default: begin
            if (sw_rst || !m_ls2) begin
               if (!m_ls2 && m_loss < 255) m_loss++;
               m_ph = 0;
            end else if (m_age < REL) m_age++;
         end
      endcase
      m_ls2 = m_ls1;
      m_ls1 = locked_in;
   endtask

   task automatic tick(input logic lk, input logic sw);
      locked_in = lk;
      sw_rst    = sw;
      @(posedge clk);
      if (rst_n) model_edge(); else model_rst();
      @(negedge clk);
   endtask

   task automatic advance_to(input int age);
      int n;
      n = 0;
      while (!(m_ph == 2 && m_age >= age) && n < 200) begin
         tick(1'b1, 1'b0);
         n++;
      end
      checks++;
      if (!(m_ph == 2 && m_age >= age)) begin
         errors++;
         $display("FAIL advance_timeout got ph=%0d age=%0d want age>=%0d", m_ph, m_age, age);
      end
   endtask

   task automatic test_reset();
      int first;
      rst_n = 1'b0;
      model_rst();
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, 1'b0);
         checks++;
         if ({state, ready, rst_stage} !== exp_vec()) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, {state, ready, rst_stage}, exp_vec());
         end
      end
      rst_n = 1'b1;
      first = 0;
      for (int i = 1; i <= 40; i++) begin
         tick(1'b1, 1'b0);
         checks++;
         if ({state, ready, rst_stage} !== exp_vec()) begin
            errors++;
            $display("FAIL powerup cyc=%0d got=%b exp=%b", i, {state, ready, rst_stage}, exp_vec());
         end
         if (ready === 1'b1 && first == 0) first = i;
      end
      checks++;
      if (first != 2 + LS + REL) begin
         errors++;
         $display("FAIL powerup_latency got=%0d exp=%0d", first, 2 + LS + REL);
      end
`ifdef RST_SEQ_LOSS_CNT_EN
      checks++;
      if (loss_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_loss_cnt got=%0d exp=0", loss_cnt);
      end
`endif
   endtask

   task automatic test_wait_glitch();
      int n;
      tick(1'b1, 1'b1);
      n = 0;
      while (!(m_ph == 1 && m_stable == 5) && n < 50) begin
         tick(1'b1, 1'b0);
         n++;
      end
      for (int i = 0; i < 3 + 20; i++) begin
         tick((i >= 3), 1'b0);
         checks++;
         if ({state, ready, rst_stage} !== exp_vec()) begin
            errors++;
            $display("FAIL wait_glitch cyc=%0d got=%b exp=%b", i, {state, ready, rst_stage}, exp_vec());
         end
      end
   endtask

   task automatic test_lock_loss_run();
      int base;
      advance_to(REL);
      base = m_loss;
      for (int i = 0; i < 30; i++) begin
         tick((i >= 2), 1'b0);
         checks++;
         if ({state, ready, rst_stage} !== exp_vec()) begin
            errors++;
            $display("FAIL lock_loss cyc=%0d got=%b exp=%b", i, {state, ready, rst_stage}, exp_vec());
         end
      end
`ifdef RST_SEQ_LOSS_CNT_EN
      checks++;
      if (loss_cnt !== 8'(base + 1) || m_loss != base + 1) begin
         errors++;
         $display("FAIL lock_loss_cnt got=%0d exp=%0d", loss_cnt, base + 1);
      end
`endif
   endtask

   task automatic test_sw_rst_release();
      int base;
      base = m_loss;
      tick(1'b1, 1'b1);
      advance_to(H + 1);
      tick(1'b1, 1'b1);
      checks++;
      if (rst_stage !== 3'b111 || ready !== 1'b0 || state !== 2'd0) begin
         errors++;
         $display("FAIL sw_rst_release got=%b/%b/%0d exp=111/0/0", rst_stage, ready, state);
      end
      for (int i = 0; i < 30; i++) begin
         tick(1'b1, 1'b0);
         checks++;
         if ({state, ready, rst_stage} !== exp_vec()) begin
            errors++;
            $display("FAIL sw_reseq cyc=%0d got=%b exp=%b", i, {state, ready, rst_stage}, exp_vec());
         end
      end
`ifdef RST_SEQ_LOSS_CNT_EN
      checks++;
      if (loss_cnt !== 8'(base)) begin
         errors++;
         $display("FAIL sw_loss_cnt got=%0d exp=%0d", loss_cnt, base);
      end
`endif
   endtask

   task automatic test_sw_held();
      for (int i = 0; i < 16; i++) begin
         tick(1'b1, (i < 6));
         checks++;
         if ({state, ready, rst_stage} !== exp_vec()) begin
            errors++;
            $display("FAIL sw_held cyc=%0d got=%b exp=%b", i, {state, ready, rst_stage}, exp_vec());
         end
      end
   endtask

   task automatic test_async_rst();
      advance_to(6);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (rst_stage !== 3'b111 || ready !== 1'b0 || state !== 2'd0) begin
         errors++;
         $display("FAIL async_rst got=%b/%b/%0d exp=111/0/0", rst_stage, ready, state);
      end
      model_rst();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick(1'b1, 1'b0);
         checks++;
         if ({state, ready, rst_stage} !== exp_vec()) begin
            errors++;
            $display("FAIL async_reseq cyc=%0d got=%b exp=%b", i, {state, ready, rst_stage}, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         tick(($urandom_range(0, 99) < 97), ($urandom_range(0, 199) == 0));
         checks++;
         if ({state, ready, rst_stage} !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc=%0d got=%b exp=%b", i, {state, ready, rst_stage}, exp_vec());
         end
`ifdef RST_SEQ_LOSS_CNT_EN
         if (loss_cnt !== 8'(m_loss)) begin
            errors++;
            $display("FAIL random_loss cyc=%0d got=%0d exp=%0d", i, loss_cnt, m_loss);
         end
`endif
      end
   endtask

`ifdef RST_SEQ_LOSS_CNT_EN
   task automatic test_saturation();
      for (int e = 0; e < 260; e++) begin
         advance_to(1);
         tick(1'b0, 1'b0);
         tick(1'b1, 1'b0);
         tick(1'b1, 1'b0);
      end
      checks++;
      if (loss_cnt !== 8'd255 || m_loss != 255) begin
         errors++;
         $display("FAIL saturation got=%0d exp=255", loss_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_wait_glitch();
      test_lock_loss_run();
      test_sw_rst_release();
      test_sw_held();
      test_async_rst();
      test_random();
`ifdef RST_SEQ_LOSS_CNT_EN
      test_saturation();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
